// File: rtl/eth_tx_frame_fifo_pkg.sv
// Shared constants for the store-and-forward Ethernet TX frame FIFO.
// A RAM word is {tuser, tlast, tdata}.
package eth_tx_frame_fifo_pkg;

  localparam int RAM_W = 10;

  function automatic logic [RAM_W-1:0] pack_beat(input logic       tuser,
                                                 input logic       tlast,
                                                 input logic [7:0] tdata);
    return {tuser, tlast, tdata};
  endfunction

endpackage

// File: rtl/eth_tx_fifo_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port.
// The read register only updates on rd_en, so it acts as a holding stage.
module eth_tx_fifo_ram
  import eth_tx_frame_fifo_pkg::*;
#(
  parameter  int WIDTH = RAM_W,
  parameter  int DEPTH = 4096,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/eth_tx_frame_fifo.sv
// Store-and-forward byte-wide AXI-Stream frame FIFO feeding the GMII transmitter.
// Frames become visible downstream only once committed; overflowed or bad frames are dropped whole.
module eth_tx_frame_fifo
  import eth_tx_frame_fifo_pkg::*;
#(
  parameter int DEPTH          = 4096,
  parameter int DROP_BAD_FRAME = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  input  logic       s_axis_tlast,
  input  logic       s_axis_tuser,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       m_axis_tlast,
  output logic       m_axis_tuser,
  output logic       status_good_frame,
  output logic       status_bad_frame,
  output logic       status_overflow
);

  localparam int        AW       = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic      DROP_BAD = (DROP_BAD_FRAME != 0);

  logic [AW:0] wr_ptr_cur_q, wr_ptr_cur_d;
  logic [AW:0] wr_ptr_commit_q, wr_ptr_commit_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        drop_frame_q, drop_frame_d;
  logic        s_tready_q;
  logic        good_q, good_d, bad_q, bad_d, ovf_q, ovf_d;
  logic        s1_valid_q, s1_valid_d;
  logic        m_tvalid_q, m_tvalid_d;
  logic [7:0]  m_tdata_q, m_tdata_d;
  logic        m_tlast_q, m_tlast_d;
  logic        m_tuser_q, m_tuser_d;

  logic             accept, full, empty, s2_ready, s1_move;
  logic             ram_wr_en, ram_rd_en;
  logic [RAM_W-1:0] ram_wr_data, ram_rd_data;

  assign accept = s_axis_tvalid & s_tready_q;
  assign full   = (wr_ptr_cur_q == {~rd_ptr_q[AW], rd_ptr_q[AW-1:0]});
  assign empty  = (rd_ptr_q == wr_ptr_commit_q);

  // Write side: speculative pointer advances per beat, commit pointer only on a good tlast
  always_comb begin
    wr_ptr_cur_d    = wr_ptr_cur_q;
    wr_ptr_commit_d = wr_ptr_commit_q;
    drop_frame_d    = drop_frame_q;
    good_d          = 1'b0;
    bad_d           = 1'b0;
    ovf_d           = 1'b0;
    ram_wr_en       = 1'b0;
    ram_wr_data     = pack_beat(DROP_BAD ? 1'b0 : (s_axis_tuser & s_axis_tlast),
                                s_axis_tlast, s_axis_tdata);
    if (accept) begin
      if (s_axis_tlast) begin
        if (drop_frame_q || full) begin
          wr_ptr_cur_d = wr_ptr_commit_q;
          drop_frame_d = 1'b0;
          ovf_d        = 1'b1;
        end else if (DROP_BAD && s_axis_tuser) begin
          wr_ptr_cur_d = wr_ptr_commit_q;
          bad_d        = 1'b1;
        end else begin
          ram_wr_en       = 1'b1;
          wr_ptr_cur_d    = wr_ptr_cur_q + PTR_ONE;
          wr_ptr_commit_d = wr_ptr_cur_q + PTR_ONE;
          good_d          = 1'b1;
        end
      end else if (!drop_frame_q) begin
        if (full) begin
          drop_frame_d = 1'b1;
        end else begin
          ram_wr_en    = 1'b1;
          wr_ptr_cur_d = wr_ptr_cur_q + PTR_ONE;
        end
      end
    end
  end

  // Read side: RAM read register is stage 1, output register is stage 2
  always_comb begin
    s2_ready   = !m_tvalid_q || m_axis_tready;
    s1_move    = s1_valid_q && s2_ready;
    ram_rd_en  = !empty && (!s1_valid_q || s1_move);
    rd_ptr_d   = ram_rd_en ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    s1_valid_d = ram_rd_en || (s1_valid_q && !s1_move);
    m_tvalid_d = m_tvalid_q;
    m_tdata_d  = m_tdata_q;
    m_tlast_d  = m_tlast_q;
    m_tuser_d  = m_tuser_q;
    if (s1_move) begin
      m_tvalid_d = 1'b1;
      m_tdata_d  = ram_rd_data[7:0];
      m_tlast_d  = ram_rd_data[8];
      m_tuser_d  = ram_rd_data[9];
    end else if (s2_ready) begin
      m_tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_cur_q    <= '0;
      wr_ptr_commit_q <= '0;
      rd_ptr_q        <= '0;
      drop_frame_q    <= 1'b0;
      s_tready_q      <= 1'b0;
      good_q          <= 1'b0;
      bad_q           <= 1'b0;
      ovf_q           <= 1'b0;
      s1_valid_q      <= 1'b0;
      m_tvalid_q      <= 1'b0;
      m_tdata_q       <= '0;
      m_tlast_q       <= 1'b0;
      m_tuser_q       <= 1'b0;
    end else begin
      wr_ptr_cur_q    <= wr_ptr_cur_d;
      wr_ptr_commit_q <= wr_ptr_commit_d;
      rd_ptr_q        <= rd_ptr_d;
      drop_frame_q    <= drop_frame_d;
      s_tready_q      <= 1'b1;
      good_q          <= good_d;
      bad_q           <= bad_d;
      ovf_q           <= ovf_d;
      s1_valid_q      <= s1_valid_d;
      m_tvalid_q      <= m_tvalid_d;
      m_tdata_q       <= m_tdata_d;
      m_tlast_q       <= m_tlast_d;
      m_tuser_q       <= m_tuser_d;
    end
  end

  eth_tx_fifo_ram #(
    .WIDTH (RAM_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (ram_wr_en),
    .wr_addr (wr_ptr_cur_q[AW-1:0]),
    .wr_data (ram_wr_data),
    .rd_en   (ram_rd_en),
    .rd_addr (rd_ptr_q[AW-1:0]),
    .rd_data (ram_rd_data)
  );

  assign s_axis_tready     = s_tready_q;
  assign m_axis_tvalid     = m_tvalid_q;
  assign m_axis_tdata      = m_tdata_q;
  assign m_axis_tlast      = m_tlast_q;
  assign m_axis_tuser      = m_tuser_q;
  assign status_good_frame = good_q;
  assign status_bad_frame  = bad_q;
  assign status_overflow   = ovf_q;

endmodule

// File: tb/tb_eth_tx_frame_fifo.sv
// Self-checking bench for eth_tx_frame_fifo (DEPTH=64) using a byte scoreboard.
// Inputs change 1ns after posedge; outputs and handshakes are observed on negedge.
module tb_eth_tx_frame_fifo;

  logic       clk;
  logic       rst;
  logic [7:0] s_axis_tdata;
  logic       s_axis_tvalid;
  logic       s_axis_tready;
  logic       s_axis_tlast;
  logic       s_axis_tuser;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready;
  logic       m_axis_tlast;
  logic       m_axis_tuser;
  logic       status_good_frame;
  logic       status_bad_frame;
  logic       status_overflow;

  int total_checks = 0;
  int fail_count   = 0;
  int good_pulses  = 0;
  int bad_pulses   = 0;
  int ovf_pulses   = 0;
  int beat_cnt     = 0;
  int valid_cnt    = 0;

  logic [8:0] sb[$];
  bit         in_frame     = 1'b0;
  bit         hold_pending = 1'b0;
  logic [8:0] held_beat;
  bit         toggle_en;

  eth_tx_frame_fifo #(
    .DEPTH          (64),
    .DROP_BAD_FRAME (1)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .s_axis_tdata      (s_axis_tdata),
    .s_axis_tvalid     (s_axis_tvalid),
    .s_axis_tready     (s_axis_tready),
    .s_axis_tlast      (s_axis_tlast),
    .s_axis_tuser      (s_axis_tuser),
    .m_axis_tdata      (m_axis_tdata),
    .m_axis_tvalid     (m_axis_tvalid),
    .m_axis_tready     (m_axis_tready),
    .m_axis_tlast      (m_axis_tlast),
    .m_axis_tuser      (m_axis_tuser),
    .status_good_frame (status_good_frame),
    .status_bad_frame  (status_bad_frame),
    .status_overflow   (status_overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Output monitor: scoreboard pops, hold stability, no mid-frame gaps, status pulse counts
  always @(negedge clk) begin
    if (rst) begin
      in_frame     = 1'b0;
      hold_pending = 1'b0;
    end else begin
      if (status_good_frame) good_pulses++;
      if (status_bad_frame)  bad_pulses++;
      if (status_overflow)   ovf_pulses++;
      if (m_axis_tvalid)     valid_cnt++;
      if (hold_pending) begin
        total_checks++;
        if (m_axis_tvalid !== 1'b1 || {m_axis_tlast, m_axis_tdata} !== held_beat) begin
          fail_count++;
          $display("[TB] FAIL hold_stable: got valid=%b beat=%h, need valid=1 beat=%h",
                   m_axis_tvalid, {m_axis_tlast, m_axis_tdata}, held_beat);
        end
        hold_pending = 1'b0;
      end
      if (in_frame) begin
        total_checks++;
        if (m_axis_tvalid !== 1'b1) begin
          fail_count++;
          $display("[TB] FAIL tvalid_gap: got tvalid=%b mid-frame, need 1", m_axis_tvalid);
        end
      end
      if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
        beat_cnt++;
        total_checks++;
        if (sb.size() == 0) begin
          fail_count++;
          $display("[TB] FAIL unexpected_beat: got last=%b data=%h, need no beat",
                   m_axis_tlast, m_axis_tdata);
        end else begin
          logic [8:0] exp_beat;
          exp_beat = sb.pop_front();
          if ({m_axis_tlast, m_axis_tdata} !== exp_beat || m_axis_tuser !== 1'b0) begin
            fail_count++;
            $display("[TB] FAIL out_beat: got last=%b data=%h user=%b, need last=%b data=%h user=0",
                     m_axis_tlast, m_axis_tdata, m_axis_tuser, exp_beat[8], exp_beat[7:0]);
          end
        end
        in_frame = !m_axis_tlast;
      end else if (m_axis_tvalid === 1'b1) begin
        hold_pending = 1'b1;
        held_beat    = {m_axis_tlast, m_axis_tdata};
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, need completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic drive_beat(input logic [7:0] data, input logic last, input logic user);
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = data;
    s_axis_tlast  = last;
    s_axis_tuser  = user;
  endtask

  task automatic send_frame(input int len, input int seed, input bit bad_flag,
                            input bit expect_out);
    for (int i = 0; i < len; i++) begin
      drive_beat(8'(seed + i * 7), (i == len - 1), bad_flag && (i == len - 1));
      if (expect_out) sb.push_back({s_axis_tlast, s_axis_tdata});
    end
  endtask

  task automatic go_idle();
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
  endtask

  task automatic wait_drain(input int max_cycles, output bit timed_out);
    int n;
    n = 0;
    while ((sb.size() != 0 || m_axis_tvalid) && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    timed_out = (n >= max_cycles);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    total_checks++;
    if ({s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser} !== 12'h000) begin
      fail_count++;
      $display("[TB] FAIL reset_outputs: got rdy=%b vld=%b data=%h last=%b user=%b, need all 0",
               s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser);
    end
    total_checks++;
    if ({status_good_frame, status_bad_frame, status_overflow} !== 3'b000) begin
      fail_count++;
      $display("[TB] FAIL reset_status: got %b%b%b, need 000",
               status_good_frame, status_bad_frame, status_overflow);
    end
    @(posedge clk);
    #3;
    rst = 1'b0;
    @(negedge clk);
    total_checks++;
    if (s_axis_tready !== 1'b0) begin
      fail_count++;
      $display("[TB] FAIL tready_before_edge: got %b, need 0", s_axis_tready);
    end
    @(posedge clk);
    #1;
    total_checks++;
    if (s_axis_tready !== 1'b1) begin
      fail_count++;
      $display("[TB] FAIL tready_after_edge: got %b, need 1", s_axis_tready);
    end
  endtask

  task automatic test_good_frame();
    int g0, b0, o0, beats0, valid0;
    bit to;
    g0 = good_pulses; b0 = bad_pulses; o0 = ovf_pulses;
    beats0 = beat_cnt; valid0 = valid_cnt;
    m_axis_tready = 1'b1;
    send_frame(60, 8'h10, 1'b0, 1'b1);
    go_idle();
    @(negedge clk);
    total_checks++;
    if (status_good_frame !== 1'b1 || m_axis_tvalid !== 1'b0) begin
      fail_count++;
      $display("[TB] FAIL commit_cycle: got good=%b vld=%b, need good=1 vld=0",
               status_good_frame, m_axis_tvalid);
    end
    @(negedge clk);
    total_checks++;
    if (m_axis_tvalid !== 1'b0) begin
      fail_count++;
      $display("[TB] FAIL latency_early: got vld=%b at N+1, need 0", m_axis_tvalid);
    end
    @(negedge clk);
    total_checks++;
    if (m_axis_tvalid !== 1'b1) begin
      fail_count++;
      $display("[TB] FAIL latency_n2: got vld=%b at N+2, need 1", m_axis_tvalid);
    end
    wait_drain(300, to);
    total_checks++;
    if (to) begin
      fail_count++;
      $display("[TB] FAIL good_drain: got %0d beats left, need 0", sb.size());
    end
    total_checks++;
    if (good_pulses - g0 != 1 || bad_pulses != b0 || ovf_pulses != o0) begin
      fail_count++;
      $display("[TB] FAIL good_status: got good=%0d bad=%0d ovf=%0d, need 1/0/0",
               good_pulses - g0, bad_pulses - b0, ovf_pulses - o0);
    end
    total_checks++;
    if (beat_cnt - beats0 != 60 || valid_cnt - valid0 != 60) begin
      fail_count++;
      $display("[TB] FAIL good_len: got beats=%0d valid_cycles=%0d, need 60/60",
               beat_cnt - beats0, valid_cnt - valid0);
    end
  endtask

  task automatic test_bad_frame();
    int g0, b0, o0, beats0;
    bit to;
    g0 = good_pulses; b0 = bad_pulses; o0 = ovf_pulses; beats0 = beat_cnt;
    send_frame(20, 8'h55, 1'b1, 1'b0);
    go_idle();
    repeat (10) @(negedge clk);
    total_checks++;
    if (bad_pulses - b0 != 1 || good_pulses != g0 || ovf_pulses != o0 || beat_cnt != beats0) begin
      fail_count++;
      $display("[TB] FAIL bad_drop: got bad=%0d good=%0d ovf=%0d beats=%0d, need 1/0/0/0",
               bad_pulses - b0, good_pulses - g0, ovf_pulses - o0, beat_cnt - beats0);
    end
    send_frame(64, 8'hA3, 1'b0, 1'b1);
    go_idle();
    wait_drain(300, to);
    total_checks++;
    if (to || good_pulses - g0 != 1 || beat_cnt - beats0 != 64) begin
      fail_count++;
      $display("[TB] FAIL after_bad: got good=%0d beats=%0d left=%0d, need 1/64/0",
               good_pulses - g0, beat_cnt - beats0, sb.size());
    end
  endtask

  task automatic test_overflow();
    int g0, b0, o0, beats0;
    bit to;
    g0 = good_pulses; b0 = bad_pulses; o0 = ovf_pulses; beats0 = beat_cnt;
    send_frame(100, 8'h21, 1'b0, 1'b0);
    go_idle();
    repeat (10) @(negedge clk);
    total_checks++;
    if (ovf_pulses - o0 != 1 || good_pulses != g0 || bad_pulses != b0 || beat_cnt != beats0) begin
      fail_count++;
      $display("[TB] FAIL overflow_drop: got ovf=%0d good=%0d bad=%0d beats=%0d, need 1/0/0/0",
               ovf_pulses - o0, good_pulses - g0, bad_pulses - b0, beat_cnt - beats0);
    end
    send_frame(64, 8'h6B, 1'b0, 1'b1);
    go_idle();
    wait_drain(300, to);
    total_checks++;
    if (to || good_pulses - g0 != 1 || beat_cnt - beats0 != 64) begin
      fail_count++;
      $display("[TB] FAIL exact_fill: got good=%0d beats=%0d left=%0d, need 1/64/0",
               good_pulses - g0, beat_cnt - beats0, sb.size());
    end
    o0 = ovf_pulses; b0 = bad_pulses;
    send_frame(100, 8'h90, 1'b1, 1'b0);
    go_idle();
    repeat (10) @(negedge clk);
    total_checks++;
    if (ovf_pulses - o0 != 1 || bad_pulses != b0) begin
      fail_count++;
      $display("[TB] FAIL ovf_priority: got ovf=%0d bad=%0d, need 1/0",
               ovf_pulses - o0, bad_pulses - b0);
    end
  endtask

  task automatic test_back_to_back();
    int g0, o0, beats0;
    bit to;
    g0 = good_pulses; o0 = ovf_pulses; beats0 = beat_cnt;
    m_axis_tready = 1'b0;
    toggle_en = 1'b1;
    to = 1'b0;
    fork
      begin
        while (toggle_en) begin
          @(posedge clk);
          #1;
          m_axis_tready = ~m_axis_tready;
        end
      end
      begin
        send_frame(17, 8'h01, 1'b0, 1'b1);
        send_frame(23, 8'h40, 1'b0, 1'b1);
        send_frame(20, 8'hE0, 1'b0, 1'b1);
        go_idle();
        wait_drain(600, to);
        toggle_en = 1'b0;
      end
    join
    m_axis_tready = 1'b1;
    total_checks++;
    if (to) begin
      fail_count++;
      $display("[TB] FAIL b2b_drain: got %0d beats left, need 0", sb.size());
    end
    total_checks++;
    if (good_pulses - g0 != 3 || ovf_pulses != o0 || beat_cnt - beats0 != 60) begin
      fail_count++;
      $display("[TB] FAIL b2b_counts: got good=%0d ovf=%0d beats=%0d, need 3/0/60",
               good_pulses - g0, ovf_pulses - o0, beat_cnt - beats0);
    end
  endtask

  task automatic test_reset_mid();
    int g0, beats0;
    bit to;
    m_axis_tready = 1'b1;
    send_frame(40, 8'h80, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) drive_beat(8'(8'hC0 + i), 1'b0, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    s_axis_tvalid = 1'b0;
    sb.delete();
    total_checks++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== 8'h00 || m_axis_tlast !== 1'b0 ||
        s_axis_tready !== 1'b0) begin
      fail_count++;
      $display("[TB] FAIL async_reset: got vld=%b data=%h last=%b rdy=%b, need 0/00/0/0",
               m_axis_tvalid, m_axis_tdata, m_axis_tlast, s_axis_tready);
    end
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk);
    g0 = good_pulses; beats0 = beat_cnt;
    send_frame(25, 8'h33, 1'b0, 1'b1);
    go_idle();
    wait_drain(300, to);
    total_checks++;
    if (to || good_pulses - g0 != 1 || beat_cnt - beats0 != 25) begin
      fail_count++;
      $display("[TB] FAIL post_reset: got good=%0d beats=%0d left=%0d, need 1/25/0",
               good_pulses - g0, beat_cnt - beats0, sb.size());
    end
  endtask

  initial begin
    rst           = 1'b1;
    s_axis_tdata  = 8'h00;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
    m_axis_tready = 1'b1;
    toggle_en     = 1'b0;
    test_reset();
    test_good_frame();
    test_bad_frame();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total_checks, fail_count);
    $finish;
  end

endmodule
